// File: rtl/quadrant_corrector_pipe_if.sv
// Stream bus of the quadrant corrector: input sample channel and corrected output channel.
// The master side is the sample source and downstream sink; the slave side is the corrector.
interface quadrant_corrector_pipe_if #(
   parameter int DATA_W  = 32,
   parameter int ANGLE_W = 32
);
   logic               in_valid;
   logic               in_ready;
   logic               in_mode;
   logic [DATA_W-1:0]  in_x;
   logic [DATA_W-1:0]  in_y;
   logic [ANGLE_W-1:0] in_angle;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_x;
   logic [DATA_W-1:0]  out_y;
   logic [ANGLE_W-1:0] out_angle;
   logic               out_flip;

   modport master (
      output in_valid, in_mode, in_x, in_y, in_angle, out_ready,
      input  in_ready, out_valid, out_x, out_y, out_angle, out_flip
   );

   modport slave (
      input  in_valid, in_mode, in_x, in_y, in_angle, out_ready,
      output in_ready, out_valid, out_x, out_y, out_angle, out_flip
   );
endinterface

// File: rtl/quadrant_corrector_pipe.sv
// CORDIC pre-rotation: folds a vector/angle into [-90deg,+90deg) via an optional 180deg flip.
// Two-stage valid/ready pipeline; define QC_SAT_EN to saturate negation of the most negative value.
module quadrant_corrector_pipe #(
   parameter int DATA_W  = 32,
   parameter int ANGLE_W = 32,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   quadrant_corrector_pipe_if.slave bus,
   input  logic                   cnt_clr,
   output logic [CNT_W-1:0]       corr_cnt
);
   localparam logic [DATA_W-1:0]  DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [ANGLE_W-1:0] HALF_TURN = {1'b1, {(ANGLE_W-1){1'b0}}};
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

   function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
`ifdef QC_SAT_EN
      negate = (v == DATA_MIN) ? ~DATA_MIN : -v;
`else
      negate = -v;
`endif
   endfunction

   logic               s1_valid_q, s1_flip_q, s1_flip_d;
   logic [DATA_W-1:0]  s1_x_q, s1_y_q;
   logic [ANGLE_W-1:0] s1_angle_q;
   logic               s2_valid_q, s2_flip_q;
   logic [DATA_W-1:0]  s2_x_q, s2_y_q, s2_x_d, s2_y_d;
   logic [ANGLE_W-1:0] s2_angle_q, s2_angle_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               adv1, adv2;

   assign adv2        = ~s2_valid_q | bus.out_ready;
   assign adv1        = ~s1_valid_q | adv2;
   assign bus.in_ready = adv1;

   // Rotation flips for quadrant bits 01/10 ([90,270)); vectoring flips on negative x.
   assign s1_flip_d = bus.in_mode ? bus.in_x[DATA_W-1]
                                  : (bus.in_angle[ANGLE_W-1] ^ bus.in_angle[ANGLE_W-2]);

   always_comb begin
      s2_x_d     = s1_x_q;
      s2_y_d     = s1_y_q;
      s2_angle_d = s1_angle_q;
      if (s1_flip_q) begin
         s2_x_d     = negate(s1_x_q);
         s2_y_d     = negate(s1_y_q);
         s2_angle_d = s1_angle_q ^ HALF_TURN;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)
         cnt_d = '0;
      else if (s2_valid_q && bus.out_ready && s2_flip_q && cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_flip_q  <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_angle_q <= '0;
      end else if (adv1) begin
         s1_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            s1_flip_q  <= s1_flip_d;
            s1_x_q     <= bus.in_x;
            s1_y_q     <= bus.in_y;
            s1_angle_q <= bus.in_angle;
         end
      end
   end

   // Output registers are held while stalled, which keeps out_* stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_flip_q  <= 1'b0;
         s2_x_q     <= '0;
         s2_y_q     <= '0;
         s2_angle_q <= '0;
      end else if (adv2) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_flip_q  <= s1_flip_q;
            s2_x_q     <= s2_x_d;
            s2_y_q     <= s2_y_d;
            s2_angle_q <= s2_angle_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign bus.out_valid = s2_valid_q;
   assign bus.out_flip  = s2_flip_q;
   assign bus.out_x     = s2_x_q;
   assign bus.out_y     = s2_y_q;
   assign bus.out_angle = s2_angle_q;
   assign corr_cnt      = cnt_q;
endmodule

// File: tb/tb_quadrant_corrector_pipe.sv
// Directed bench for quadrant_corrector_pipe: main 32-bit instance plus a CNT_W=2 instance
// for counter saturation and clear priority.
module tb_quadrant_corrector_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cnt_clr = 1'b0;
   logic        cnt_clr2 = 1'b0;
   logic [15:0] corr_cnt;
   logic [1:0]  corr_cnt2;

   int n_total = 0;
   int n_pass  = 0;
   int exp_cnt = 0;
   int si, ri;
   logic        held_v;
   logic [31:0] held_x, held_a, ex, ey, ea;
   logic        ef;
   logic [31:0] sat_x;

   quadrant_corrector_pipe_if #(.DATA_W(32), .ANGLE_W(32)) bus ();
   quadrant_corrector_pipe_if #(.DATA_W(32), .ANGLE_W(32)) bus2 ();

   quadrant_corrector_pipe #(.DATA_W(32), .ANGLE_W(32), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt)
   );

   quadrant_corrector_pipe #(.DATA_W(32), .ANGLE_W(32), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .cnt_clr(cnt_clr2), .corr_cnt(corr_cnt2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends one sample on the main instance and checks latency, result and counter.
   task automatic xfer(input string tag, input logic mode, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] a, input logic [31:0] ex_x, input logic [31:0] ex_y,
                       input logic [31:0] ex_a, input logic ex_f);
      bus.in_mode = mode; bus.in_x = x; bus.in_y = y; bus.in_angle = a;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
      step();
      check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_x"}, 64'(bus.out_x), 64'(ex_x));
      check({tag, "_y"}, 64'(bus.out_y), 64'(ex_y));
      check({tag, "_angle"}, 64'(bus.out_angle), 64'(ex_a));
      check({tag, "_flip"}, 64'(bus.out_flip), 64'(ex_f));
      if (ex_f) exp_cnt++;
      step();
      check({tag, "_cnt"}, 64'(corr_cnt), 64'(exp_cnt));
      check({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      bus.in_valid = 0; bus.in_mode = 0; bus.in_x = 0; bus.in_y = 0; bus.in_angle = 0; bus.out_ready = 1;
      bus2.in_valid = 0; bus2.in_mode = 0; bus2.in_x = 32'd1; bus2.in_y = 32'd1;
      bus2.in_angle = 32'h8000_0000; bus2.out_ready = 1;
      repeat (3) step();
      @(negedge clk) rst_n = 1'b1;
      step();

      // Reset state
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_x", 64'(bus.out_x), 64'd0);
      check("rst_out_y", 64'(bus.out_y), 64'd0);
      check("rst_out_angle", 64'(bus.out_angle), 64'd0);
      check("rst_out_flip", 64'(bus.out_flip), 64'd0);
      check("rst_cnt", 64'(corr_cnt), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Rotation pass-through and flips
      xfer("rot_pass1", 0, 32'd20, 32'd40, 32'h1000_0000, 32'd20, 32'd40, 32'h1000_0000, 0);
      xfer("rot_pass3", 0, 32'd20, 32'd40, 32'h3000_0000, 32'd20, 32'd40, 32'h3000_0000, 0);
      xfer("rot_flip5", 0, 32'd20, 32'd40, 32'h5000_0000, 32'hFFFF_FFEC, 32'hFFFF_FFD8, 32'hD000_0000, 1);
      xfer("rot_flip90", 0, 32'd20, 32'd40, 32'h4000_0000, 32'hFFFF_FFEC, 32'hFFFF_FFD8, 32'hC000_0000, 1);
      xfer("rot_passC", 0, 32'd20, 32'd40, 32'hC000_0000, 32'd20, 32'd40, 32'hC000_0000, 0);
      xfer("rot_edgeBF", 0, 32'd7, 32'd9, 32'hBFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF7, 32'h3FFF_FFFF, 1);

      // Vectoring
      xfer("vec_neg", 1, 32'hFFFF_FFEC, 32'd40, 32'h0, 32'd20, 32'hFFFF_FFD8, 32'h8000_0000, 1);
      xfer("vec_zero", 1, 32'd0, 32'd5, 32'h1234_5678, 32'd0, 32'd5, 32'h1234_5678, 0);
      xfer("vec_pos_bigang", 1, 32'd3, 32'd4, 32'h6000_0000, 32'd3, 32'd4, 32'h6000_0000, 0);

      // Backpressure: 8-sample burst with out_ready low for cycles 3..5
      si = 0; ri = 0; held_v = 0; held_x = 0; held_a = 0;
      for (int c = 0; c < 40 && ri < 8; c++) begin
         bus.out_ready = !(c >= 3 && c <= 5);
         bus.in_valid  = (si < 8);
         bus.in_mode   = 1'b0;
         bus.in_x      = 32'(si + 1);
         bus.in_y      = 32'(100 + si);
         bus.in_angle  = 32'(si) << 28;
         #3;
         if (held_v) begin
            check("bp_stable_x", 64'(bus.out_x), 64'(held_x));
            check("bp_stable_angle", 64'(bus.out_angle), 64'(held_a));
            check("bp_stable_valid", 64'(bus.out_valid), 64'd1);
         end
         if (c == 4) check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
         held_v = bus.out_valid && !bus.out_ready;
         held_x = bus.out_x;
         held_a = bus.out_angle;
         if (bus.out_valid && bus.out_ready) begin
            ea = 32'(ri) << 28;
            ef = (ea >= 32'h4000_0000) && (ea < 32'hC000_0000);
            ex = ef ? 32'(0 - (ri + 1)) : 32'(ri + 1);
            ey = ef ? 32'(0 - (100 + ri)) : 32'(100 + ri);
            if (ef) ea = ea + 32'h8000_0000;
            check("bp_x", 64'(bus.out_x), 64'(ex));
            check("bp_y", 64'(bus.out_y), 64'(ey));
            check("bp_angle", 64'(bus.out_angle), 64'(ea));
            check("bp_flip", 64'(bus.out_flip), 64'(ef));
            if (ef) exp_cnt++;
            ri++;
         end
         if (bus.in_valid && bus.in_ready) si++;
         step();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      check("bp_received", 64'(ri), 64'd8);
      step();
      check("bp_cnt", 64'(corr_cnt), 64'(exp_cnt));

      // Most-negative negation
`ifdef QC_SAT_EN
      sat_x = 32'h7FFF_FFFF;
`else
      sat_x = 32'h8000_0000;
`endif
      xfer("sat_neg", 0, 32'h8000_0000, 32'd1, 32'h6000_0000, sat_x, 32'hFFFF_FFFF, 32'hE000_0000, 1);

      // CNT_W=2 instance: 5 flips saturate at 3
      bus2.in_valid = 1'b1;
      repeat (5) step();
      bus2.in_valid = 1'b0;
      repeat (3) step();
      check("cnt2_sat", 64'(corr_cnt2), 64'd3);
      cnt_clr2 = 1'b1;
      step();
      cnt_clr2 = 1'b0;
      check("cnt2_clr", 64'(corr_cnt2), 64'd0);
      bus2.in_valid = 1'b1;
      step();
      bus2.in_valid = 1'b0;
      step();
      check("cnt2_out_flip", 64'(bus2.out_flip & bus2.out_valid), 64'd1);
      cnt_clr2 = 1'b1;
      step();
      cnt_clr2 = 1'b0;
      check("cnt2_clr_prio", 64'(corr_cnt2), 64'd0);

      // Reset with both stages full
      bus.out_ready = 1'b0;
      bus.in_mode = 0; bus.in_x = 32'd11; bus.in_y = 32'd12; bus.in_angle = 32'h5000_0000;
      bus.in_valid = 1'b1;
      step();
      step();
      bus.in_valid = 1'b0;
      check("mid_full_valid", 64'(bus.out_valid), 64'd1);
      check("mid_full_in_ready", 64'(bus.in_ready), 64'd0);
      check("mid_cnt_nonzero", 64'(corr_cnt != 0), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_cnt", 64'(corr_cnt), 64'd0);
      check("mid_rst_x", 64'(bus.out_x), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      exp_cnt = 0;
      bus.out_ready = 1'b1;
      step();
      check("post_rst_empty", 64'(bus.out_valid), 64'd0);
      xfer("post_rst", 0, 32'd5, 32'd6, 32'h2000_0000, 32'd5, 32'd6, 32'h2000_0000, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
